dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DMEM_ADDR_WIDTH, default 12, byte-address width of the data memory.
REQ-002 i_clk  input  1  single clock; all state on rising edge.
REQ-003 i_rstn  input  1  reset, synchronous, active-low.
REQ-004 i_mN_req  input  1  request valid from master N (N=0,1); held until o_mN_gnt.
REQ-005 i_mN_we  input  1  1 = store, 0 = load.
REQ-006 i_mN_addr  input  DMEM_ADDR_WIDTH  byte address.
REQ-007 i_mN_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 i_mN_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 i_mN_wdata  input  32  store data, right-aligned (bits [7:0] for byte).
REQ-010 o_mN_gnt  output  1  request accepted this cycle.
REQ-011 o_mN_rvalid  output  1  one-cycle response pulse, loads and stores.
REQ-012 o_mN_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 o_mN_err  output  1  misaligned or illegal-size access; qualified by o_mN_rvalid.
REQ-014 o_mem_addr  output  DMEM_ADDR_WIDTH  address to the dmem.
REQ-015 o_mem_read  output  1  dmem read enable.
REQ-016 o_mem_write  output  1  dmem write enable.
REQ-017 o_mem_size  output  4  byte-lane strobe; bit k enables byte lane k.
REQ-018 o_mem_din  output  32  lane-steered write data.
REQ-019 i_mem_dout  input  32  dmem read data, valid one cycle after o_mem_read.

Function
REQ-020 Grant is combinational; at most one o_mN_gnt is high per cycle; the granted request drives the memory port in the same cycle.
REQ-021 Arbitration is round-robin using a last-granted register (lg):
- Only one master requesting: that master is granted.
- Both requesting: the master not equal to lg is granted.
- lg updates to the granted master on every grant.
REQ-022 A request is legal when:
- size=00; or
- size=01 with addr[0]=0; or
- size=10 with addr[1:0]=00.
REQ-023 A granted legal load asserts o_mem_read=1 and o_mem_write=0; a granted legal store asserts o_mem_write=1 and o_mem_read=0.
REQ-024 In both cases o_mem_addr = request addr.
REQ-025 o_mem_size lane strobe:
- byte: 4'b0001 << addr[1:0].
- half: 4'b0011 << addr[1:0].
- word: 4'b1111.
- Loads drive the same strobe.
REQ-026 o_mem_din:
- byte: wdata[7:0] replicated to all four lanes.
- half: wdata[15:0] replicated to both halves.
- word: wdata unchanged.
REQ-027 A granted illegal request is still granted but drives o_mem_read=0, o_mem_write=0 and o_mem_size=0.
REQ-028 With no grant, o_mem_read=0 and o_mem_write=0; o_mem_addr, o_mem_size and o_mem_din are don't-care but SHALL be 0.
REQ-029 Response pipeline register captures, on each grant:
- valid;
- master id;
- we;
- size;
- unsigned;
- addr[1:0];
- err.
REQ-030 The response for a grant in cycle T appears in cycle T+1 on the granted master only: o_mN_rvalid=1 for exactly one cycle; the other master's rvalid stays 0.
REQ-031 Load rdata is extracted from i_mem_dout in cycle T+1 (combinationally from the registered offset):
- byte = dout[8*off+7 : 8*off];
- half = dout[16*off[1]+15 : 16*off[1]];
- word = dout.
- The result is then sign- or zero-extended per the registered unsigned bit.
REQ-032 For stores and errors, o_mN_rdata=0; o_mN_err=1 only for error responses.
REQ-033 A new grant is allowed every cycle, including the cycle in which a previous response is returned (full throughput, no stall).
REQ-034 Responses carry no backpressure; masters SHALL accept rvalid unconditionally.
REQ-035 While a request is asserted and not granted, the master holds all of its request fields stable; the arbiter does not latch them.

Reset
REQ-036 While i_rstn=0 at a clock edge, the following are cleared:
- lg = 1 (master 0 wins the first contention);
- response valid = 0;
- all response fields = 0.
REQ-037 While i_rstn=0, o_mN_gnt, o_mem_read and o_mem_write are forced to 0.
REQ-038 Reset outputs: o_mN_rvalid=0, o_mN_rdata=0, o_mN_err=0 from the first reset edge.
REQ-039 A response pending at a reset edge is discarded; no rvalid is issued for it after reset.

Verification
REQ-040 Word store then load: m0 stores 0xDEADBEEF at 0x010, then loads 0x010 -> o_mem_size=4'b1111 on the store; m0_rvalid in T+1 of the load with rdata=0xDEADBEEF.
REQ-041 Byte lanes: m1 stores byte 0x80 at 0x013 -> o_mem_size=4'b1000, o_mem_din=0x80808080; signed byte load of 0x013 -> rdata=0xFFFFFF80; unsigned load -> 0x00000080.
REQ-042 Half load: half load at 0x012 after word 0x1234ABCD stored at 0x010 -> signed 0x00001234; half at 0x010 -> signed 0xFFFFABCD.
REQ-043 Contention: both masters request every cycle for 6 cycles after reset -> grants alternate m0, m1, m0, m1, m0, m1; each rvalid lands on the correct master one cycle after its grant.
REQ-044 Misaligned access: word load at 0x006 or size=11 -> gnt=1, o_mem_read=0, o_mem_write=0, next cycle rvalid=1, err=1, rdata=0; memory contents unchanged.
REQ-045 Reset mid-operation: load granted in cycle T, i_rstn=0 at the T+1 edge -> no rvalid in any later cycle, lg=1, and after release m0 wins a simultaneous request.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port byte-laned data memory.
// Combinational grant and memory drive; one-cycle registered response with load extraction.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_m0_req,
  input  logic                       i_m0_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [1:0]                 i_m0_size,
  input  logic                       i_m0_unsigned,
  input  logic [31:0]                i_m0_wdata,
  output logic                       o_m0_gnt,
  output logic                       o_m0_rvalid,
  output logic [31:0]                o_m0_rdata,
  output logic                       o_m0_err,
  input  logic                       i_m1_req,
  input  logic                       i_m1_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [1:0]                 i_m1_size,
  input  logic                       i_m1_unsigned,
  input  logic [31:0]                i_m1_wdata,
  output logic                       o_m1_gnt,
  output logic                       o_m1_rvalid,
  output logic [31:0]                o_m1_rdata,
  output logic                       o_m1_err,
  output logic [DMEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                       o_mem_read,
  output logic                       o_mem_write,
  output logic [3:0]                 o_mem_size,
  output logic [31:0]                o_mem_din,
  input  logic [31:0]                i_mem_dout
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (off[0] == 1'b0);
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << off;
      SZ_HALF: strb = 4'b0011 << off;
      SZ_WORD: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] din;
    case (size)
      SZ_BYTE: din = {4{wdata[7:0]}};
      SZ_HALF: din = {2{wdata[15:0]}};
      SZ_WORD: din = wdata;
      default: din = 32'h0000_0000;
    endcase
    return din;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] dout, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = dout[{off, 3'b000} +: 8];
    h = off[1] ? dout[31:16] : dout[15:0];
    case (size)
      SZ_BYTE: res = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      SZ_WORD: res = dout;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  logic                       lg_r;
  logic                       sel_s;
  logic                       any_s;
  logic                       req_we_s;
  logic [DMEM_ADDR_WIDTH-1:0] req_addr_s;
  logic [1:0]                 req_size_s;
  logic                       req_uns_s;
  logic [31:0]                req_wdata_s;
  logic                       legal_s;

  logic        resp_valid_r;
  logic        resp_id_r;
  logic        resp_we_r;
  logic [1:0]  resp_size_r;
  logic        resp_uns_r;
  logic [1:0]  resp_off_r;
  logic        resp_err_r;
  logic [31:0] resp_data_s;

  // Round-robin select: on contention the master that was not granted last wins.
  always_comb begin
    sel_s = 1'b0;
    any_s = i_rstn & (i_m0_req | i_m1_req);
    if (i_m0_req && i_m1_req) begin
      sel_s = ~lg_r;
    end else if (i_m1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  assign o_m0_gnt = any_s & ~sel_s;
  assign o_m1_gnt = any_s & sel_s;

  // Mux the selected master's request fields.
  always_comb begin
    req_we_s    = 1'b0;
    req_addr_s  = {DMEM_ADDR_WIDTH{1'b0}};
    req_size_s  = 2'b00;
    req_uns_s   = 1'b0;
    req_wdata_s = 32'h0000_0000;
    if (sel_s) begin
      req_we_s    = i_m1_we;
      req_addr_s  = i_m1_addr;
      req_size_s  = i_m1_size;
      req_uns_s   = i_m1_unsigned;
      req_wdata_s = i_m1_wdata;
    end else begin
      req_we_s    = i_m0_we;
      req_addr_s  = i_m0_addr;
      req_size_s  = i_m0_size;
      req_uns_s   = i_m0_unsigned;
      req_wdata_s = i_m0_wdata;
    end
    legal_s = is_legal(req_size_s, req_addr_s[1:0]);
  end

  // Memory port drive; everything is zero unless a request is granted.
  always_comb begin
    o_mem_addr  = {DMEM_ADDR_WIDTH{1'b0}};
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_size  = 4'b0000;
    o_mem_din   = 32'h0000_0000;
    if (any_s) begin
      o_mem_addr = req_addr_s;
      if (legal_s) begin
        o_mem_read  = ~req_we_s;
        o_mem_write = req_we_s;
        o_mem_size  = lane_strobe(req_size_s, req_addr_s[1:0]);
        o_mem_din   = req_we_s ? steer_wdata(req_size_s, req_wdata_s) : 32'h0000_0000;
      end else begin
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
      end
    end else begin
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
    end
  end

  // Last-granted pointer and response pipeline register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      lg_r         <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_we_r    <= 1'b0;
      resp_size_r  <= 2'b00;
      resp_uns_r   <= 1'b0;
      resp_off_r   <= 2'b00;
      resp_err_r   <= 1'b0;
    end else begin
      resp_valid_r <= any_s;
      if (any_s) begin
        lg_r        <= sel_s;
        resp_id_r   <= sel_s;
        resp_we_r   <= req_we_s;
        resp_size_r <= req_size_s;
        resp_uns_r  <= req_uns_s;
        resp_off_r  <= req_addr_s[1:0];
        resp_err_r  <= ~legal_s;
      end
    end
  end

  // Load data is extracted from the memory output using the registered offset.
  always_comb begin
    resp_data_s = 32'h0000_0000;
    if (resp_valid_r && !resp_we_r && !resp_err_r) begin
      resp_data_s = extract_load(i_mem_dout, resp_size_r, resp_off_r, resp_uns_r);
    end else begin
      resp_data_s = 32'h0000_0000;
    end
  end

  assign o_m0_rvalid = resp_valid_r & ~resp_id_r;
  assign o_m1_rvalid = resp_valid_r & resp_id_r;
  assign o_m0_rdata  = resp_id_r ? 32'h0000_0000 : resp_data_s;
  assign o_m1_rdata  = resp_id_r ? resp_data_s : 32'h0000_0000;
  assign o_m0_err    = o_m0_rvalid & resp_err_r;
  assign o_m1_err    = o_m1_rvalid & resp_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of per-cycle vectors, a byte-laned memory
// model, a response scoreboard, and hand sequences for reset and mid-operation reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m0_we, m0_uns, m1_req, m1_we, m1_uns;
  logic [11:0] m0_addr, m1_addr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [11:0] mem_addr;
  logic        mem_read, mem_write;
  logic [3:0]  mem_size;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = 32'h0000_0000;

  dmem_arbiter #(.DMEM_ADDR_WIDTH(12)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_size(m0_size),
    .i_m0_unsigned(m0_uns), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata), .o_m0_err(m0_err),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_size(m1_size),
    .i_m1_unsigned(m1_uns), .i_m1_wdata(m1_wdata),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata), .o_m1_err(m1_err),
    .o_mem_addr(mem_addr), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_size(mem_size), .o_mem_din(mem_din), .i_mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req0, we0, uns0, req1, we1, uns1;
    logic [11:0] addr0, addr1;
    logic [1:0]  size0, size1;
    logic [31:0] wd0, wd1;
    logic        g0, g1, rd, wr;
    logic [11:0] ea;
    logic [3:0]  strb;
    logic [31:0] din, rdata;
    logic        err;
  } vec_t;

  typedef struct {
    int          due;
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  vec_t  vecs[$];
  resp_t exp_q[$];
  int    n_chk = 0, n_pass = 0, cyc = 0;
  logic  mon_en = 1'b0;
  logic [7:0] mem [0:4095];

  // Byte-laned synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      for (int k = 0; k < 4; k++)
        if (mem_size[k]) mem[{mem_addr[11:2], 2'b00} + k] <= mem_din[8*k +: 8];
    end
    if (mem_read) begin
      mem_dout <= {mem[{mem_addr[11:2], 2'b11}], mem[{mem_addr[11:2], 2'b10}],
                   mem[{mem_addr[11:2], 2'b01}], mem[{mem_addr[11:2], 2'b00}]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Response scoreboard: every cycle either the due response or silence.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (exp_q[0].m == 1'b0) begin
          chk("rsp m0 rvalid", {31'd0, m0_rvalid}, 32'd1);
          chk("rsp m1 rvalid quiet", {31'd0, m1_rvalid}, 32'd0);
          chk("rsp m0 rdata", m0_rdata, exp_q[0].rdata);
          chk("rsp m0 err", {31'd0, m0_err}, {31'd0, exp_q[0].err});
        end else begin
          chk("rsp m1 rvalid", {31'd0, m1_rvalid}, 32'd1);
          chk("rsp m0 rvalid quiet", {31'd0, m0_rvalid}, 32'd0);
          chk("rsp m1 rdata", m1_rdata, exp_q[0].rdata);
          chk("rsp m1 err", {31'd0, m1_err}, {31'd0, exp_q[0].err});
        end
        void'(exp_q.pop_front());
      end else begin
        chk("idle rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      end
    end
  end

  function automatic vec_t single(input logic m, input logic we, input logic [11:0] a,
                                  input logic [1:0] sz, input logic u, input logic [31:0] wd,
                                  input logic rd, input logic wr, input logic [3:0] st,
                                  input logic [31:0] din, input logic [31:0] rdata,
                                  input logic err);
    vec_t v = '{default: '0};
    if (m) begin
      v.req1 = 1'b1; v.we1 = we; v.addr1 = a; v.size1 = sz; v.uns1 = u; v.wd1 = wd;
    end else begin
      v.req0 = 1'b1; v.we0 = we; v.addr0 = a; v.size0 = sz; v.uns0 = u; v.wd0 = wd;
    end
    v.g0 = ~m; v.g1 = m; v.rd = rd; v.wr = wr; v.ea = a; v.strb = st;
    v.din = din; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  function automatic vec_t contend(input logic gm);
    vec_t v = '{default: '0};
    v.req0 = 1'b1; v.we0 = 1'b1; v.addr0 = 12'h100; v.size0 = 2'b10; v.wd0 = 32'hA0A0_A0A0;
    v.req1 = 1'b1; v.we1 = 1'b1; v.addr1 = 12'h104; v.size1 = 2'b10; v.wd1 = 32'hB1B1_B1B1;
    v.g0 = ~gm; v.g1 = gm; v.wr = 1'b1; v.strb = 4'b1111;
    v.ea  = gm ? 12'h104 : 12'h100;
    v.din = gm ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    m0_req = v.req0; m0_we = v.we0; m0_addr = v.addr0; m0_size = v.size0;
    m0_uns = v.uns0; m0_wdata = v.wd0;
    m1_req = v.req1; m1_we = v.we1; m1_addr = v.addr1; m1_size = v.size1;
    m1_uns = v.uns1; m1_wdata = v.wd1;
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    idle = '{default: '0};
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    for (int i = 0; i < 6; i++) vecs.push_back(contend(i[0]));
    vecs.push_back(single(1'b0, 1'b1, 12'h010, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0));
    vecs.push_back(single(1'b0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(single(1'b1, 1'b1, 12'h013, 2'b00, 1'b0, 32'h1234_5680, 1'b0, 1'b1, 4'b1000, 32'h8080_8080, 32'h0, 1'b0));
    vecs.push_back(single(1'b1, 1'b0, 12'h013, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0));
    vecs.push_back(single(1'b1, 1'b0, 12'h013, 2'b00, 1'b1, 32'h0, 1'b1, 1'b0, 4'b1000, 32'h0, 32'h0000_0080, 1'b0));
    vecs.push_back(single(1'b0, 1'b1, 12'h010, 2'b10, 1'b0, 32'h1234_ABCD, 1'b0, 1'b1, 4'b1111, 32'h1234_ABCD, 32'h0, 1'b0));
    vecs.push_back(single(1'b0, 1'b0, 12'h012, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1100, 32'h0, 32'h0000_1234, 1'b0));
    vecs.push_back(single(1'b0, 1'b0, 12'h010, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0011, 32'h0, 32'hFFFF_ABCD, 1'b0));
    vecs.push_back(single(1'b0, 1'b0, 12'h010, 2'b01, 1'b1, 32'h0, 1'b1, 1'b0, 4'b0011, 32'h0, 32'h0000_ABCD, 1'b0));
    vecs.push_back(single(1'b1, 1'b1, 12'h016, 2'b01, 1'b0, 32'h5555_BEEF, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0));
    vecs.push_back(single(1'b0, 1'b0, 12'h014, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'hBEEF_0000, 1'b0));
    vecs.push_back(single(1'b0, 1'b0, 12'h006, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1));
    vecs.push_back(single(1'b1, 1'b1, 12'h010, 2'b11, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1));
    vecs.push_back(single(1'b1, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h1234_ABCD, 1'b0));
    vecs.push_back(single(1'b0, 1'b1, 12'h011, 2'b01, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1));
    vecs.push_back(idle);
    vecs.push_back(single(1'b0, 1'b0, 12'h011, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0010, 32'h0, 32'hFFFF_FFAB, 1'b0));
    vecs.push_back(single(1'b1, 1'b0, 12'h017, 2'b00, 1'b1, 32'h0, 1'b1, 1'b0, 4'b1000, 32'h0, 32'h0000_00BE, 1'b0));

    // Reset with both masters requesting: no grant, no memory access, no response.
    rstn = 1'b0;
    v = contend(1'b0);
    drive(v);
    @(posedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("reset mem rd/wr", {30'd0, mem_write, mem_read}, 32'd0);
      @(posedge clk);
    end
    #1;
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d gnt0", i), {31'd0, m0_gnt}, {31'd0, vecs[i].g0});
      chk($sformatf("v%0d gnt1", i), {31'd0, m1_gnt}, {31'd0, vecs[i].g1});
      chk($sformatf("v%0d mem_read", i), {31'd0, mem_read}, {31'd0, vecs[i].rd});
      chk($sformatf("v%0d mem_write", i), {31'd0, mem_write}, {31'd0, vecs[i].wr});
      chk($sformatf("v%0d mem_size", i), {28'd0, mem_size}, {28'd0, vecs[i].strb});
      if (vecs[i].rd || vecs[i].wr || !(vecs[i].g0 || vecs[i].g1))
        chk($sformatf("v%0d mem_addr", i), {20'd0, mem_addr}, {20'd0, vecs[i].ea});
      if (vecs[i].wr || !(vecs[i].g0 || vecs[i].g1))
        chk($sformatf("v%0d mem_din", i), mem_din, vecs[i].din);
      if (vecs[i].g0 || vecs[i].g1)
        exp_q.push_back('{due: cyc + 1, m: vecs[i].g1, rdata: vecs[i].rdata, err: vecs[i].err});
      @(posedge clk);
      #1;
    end

    // Reset lands on the edge that would capture m0's load: the response must vanish.
    v = single(1'b0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0);
    drive(v);
    @(negedge clk);
    chk("midrst load gnt0", {31'd0, m0_gnt}, 32'd1);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    v = contend(1'b0);
    drive(v);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst gnt forced", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      @(posedge clk);
    end
    #1;
    rstn = 1'b1;
    v = single(1'b0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0);
    v.req1 = 1'b1; v.addr1 = 12'h014; v.size1 = 2'b10;
    drive(v);
    @(negedge clk);
    chk("post-rst contention gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    exp_q.push_back('{due: cyc + 1, m: 1'b0, rdata: 32'h1234_ABCD, err: 1'b0});
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("post-rst m1 gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    exp_q.push_back('{due: cyc + 1, m: 1'b1, rdata: 32'hBEEF_0000, err: 1'b0});
    @(posedge clk);
    #1;
    drive(idle);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
